demux1_8_sipo: RTL and testbench

DEMUX1_8_SIPO -- requirements
Module: demux1_8_sipo

---
 rtl/demux_pkg.sv | 7 +
 rtl/idle_timer.sv | 21 ++
 rtl/demux1_8_sipo.sv | 95 +++++++++
 tb/tb_demux1_8_sipo.sv | 133 +++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared frame width, counter width and FSM encoding for the SIPO demux
package demux_pkg;
  localparam int FRAME_W = 8;
  localparam int PTR_W   = 3;
  localparam int CNT_W   = 8;
  typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts consecutive idle cycles and flags the cycle that reaches TIMEOUT
module idle_timer
  import demux_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign expired = run && !kick && (cnt_q == CNT_W'(TIMEOUT - 1));
  // restart on any kick or on expiry, otherwise advance only while running
  always_comb cnt_d = (kick || expired) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  // idle count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/demux1_8_sipo.sv
// demux1_8_sipo: serial bits routed into an 8-position frame, published when every position is written
module demux1_8_sipo
  import demux_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             addr_mode,
  input  logic [PTR_W-1:0] sel,
  input  logic             clear,
  output logic             D0,
  output logic             D1,
  output logic             D2,
  output logic             D3,
  output logic             D4,
  output logic             D5,
  output logic             D6,
  output logic             D7,
  output logic             frame_valid,
  output logic [FRAME_W-1:0] fill_mask,
  output logic             timeout_err
);
  state_t               state_q;
  logic [FRAME_W-1:0]   mask_q, shadow_q, dout_q;
  logic [PTR_W-1:0]     ptr_q;
  logic                 frame_valid_q, timeout_err_q;
  logic                 accept, complete, expired, run;
  logic [PTR_W-1:0]     tgt;
  logic [FRAME_W-1:0]   onehot, mask_d, shadow_d;

  // clear wins over din_valid, so a bit arriving with clear is simply dropped
  assign accept   = din_valid && !clear;
  assign tgt      = addr_mode ? sel : ptr_q;
  assign onehot   = FRAME_W'(1) << tgt;
  assign mask_d   = mask_q | onehot;
  assign shadow_d = din ? (shadow_q | onehot) : (shadow_q & ~onehot);
  assign complete = accept && (&mask_d);
  // only idle cycles inside a partial frame count toward the abort
  assign run      = (state_q == FILL) && !din_valid && !clear;

  idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .kick   (accept || clear),
    .expired(expired)
  );

  // frame assembly FSM: clear, then completion, then plain accept, then timeout abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      shadow_q      <= '0;
      dout_q        <= '0;
      ptr_q         <= '0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      if (clear) begin
        state_q  <= IDLE;
        mask_q   <= '0;
        shadow_q <= '0;
        ptr_q    <= '0;
      end else if (complete) begin
        state_q       <= IDLE;
        dout_q        <= shadow_d;
        mask_q        <= '0;
        shadow_q      <= '0;
        ptr_q         <= '0;
        frame_valid_q <= 1'b1;
      end else if (accept) begin
        state_q  <= FILL;
        mask_q   <= mask_d;
        shadow_q <= shadow_d;
        ptr_q    <= addr_mode ? ptr_q : ptr_q + 1'b1;
      end else if (expired) begin
        state_q       <= IDLE;
        mask_q        <= '0;
        shadow_q      <= '0;
        ptr_q         <= '0;
        timeout_err_q <= 1'b1;
      end
    end

  assign {D7, D6, D5, D4, D3, D2, D1, D0} = dout_q;
  assign fill_mask   = mask_q;
  assign frame_valid = frame_valid_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_demux1_8_sipo.sv
// tb_demux1_8_sipo: directed vectors with hand-computed expectations for the SIPO demux
module tb_demux1_8_sipo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0, din_valid = 1'b0, addr_mode = 1'b0, clear = 1'b0;
  logic [2:0] sel = '0;
  logic       D0, D1, D2, D3, D4, D5, D6, D7;
  logic       frame_valid, timeout_err;
  logic [7:0] fill_mask;
  logic [7:0] dout;
  int         n_vec = 0, n_bad = 0;
  int         terr_seen;

  demux1_8_sipo #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .addr_mode(addr_mode), .sel(sel), .clear(clear),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .frame_valid(frame_valid), .fill_mask(fill_mask), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  assign dout = {D7, D6, D5, D4, D3, D2, D1, D0};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic b, input logic dv, input logic am, input logic [2:0] s, input logic clr);
    din = b; din_valid = dv; addr_mode = am; sel = s; clear = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) apply(v[i], 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  localparam logic [2:0] ASEL [9] = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  localparam logic       ABIT [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #12;
    check("rst_dout", dout, 8'h00);
    check("rst_mask", fill_mask, 8'h00);
    check("rst_pulses", {6'd0, frame_valid, timeout_err}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // auto frame 1,0,1,1,0,0,1,0 on D0..D7
    send_byte(8'h4D);
    check("auto_fv", {7'd0, frame_valid}, 8'h01);
    check("auto_dout", dout, 8'h4D);
    check("auto_mask", fill_mask, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("auto_fv_drop", {7'd0, frame_valid}, 8'h00);

    // addressed mode with a rewrite of position 3
    for (int i = 0; i < 9; i++) begin
      apply(ABIT[i], 1'b1, 1'b1, ASEL[i], 1'b0);
      if (i == 2) check("addr_mask_rewrite", fill_mask, 8'h88);
      if (i == 7) check("addr_mask_pre", fill_mask, 8'hBF);
      if (i < 8)  check("addr_no_fv", {7'd0, frame_valid}, 8'h00);
    end
    check("addr_fv", {7'd0, frame_valid}, 8'h01);
    check("addr_dout", dout, 8'hD3);
    check("addr_mask", fill_mask, 8'h00);

    // idle cycles with an empty frame must never time out
    terr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      if (timeout_err) terr_seen++;
    end
    check("idle_no_terr", 8'(terr_seen), 8'h00);

    // three bits then 16 idle cycles -> abort
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    check("to_mask_partial", fill_mask, 8'h07);
    terr_seen = 0;
    for (int i = 0; i < 15; i++) begin
      apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      if (timeout_err) terr_seen++;
    end
    check("to_early", 8'(terr_seen), 8'h00);
    check("to_mask_held", fill_mask, 8'h07);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("to_terr", {7'd0, timeout_err}, 8'h01);
    check("to_mask", fill_mask, 8'h00);
    check("to_dout_kept", dout, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("to_terr_drop", {7'd0, timeout_err}, 8'h00);
    send_byte(8'h5A);
    check("to_next_dout", dout, 8'h5A);

    // five bits then clear together with a valid bit
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    check("clr_mask", fill_mask, 8'h00);
    check("clr_pulses", {6'd0, frame_valid, timeout_err}, 8'h00);
    check("clr_dout_kept", dout, 8'h5A);
    send_byte(8'h0F);
    check("clr_next_fv", {7'd0, frame_valid}, 8'h01);
    check("clr_next_dout", dout, 8'h0F);

    // back-to-back frames, pulses 8 cycles apart
    for (int i = 0; i < 16; i++) begin
      apply(i < 8 ? 1'((8'hA5 >> i) & 1) : 1'((8'h3C >> (i - 8)) & 1), 1'b1, 1'b0, 3'd0, 1'b0);
      if (i == 7)  check("b2b_dout1", dout, 8'hA5);
      if (i == 15) check("b2b_dout2", dout, 8'h3C);
      check("b2b_fv", {7'd0, frame_valid}, (i == 7 || i == 15) ? 8'h01 : 8'h00);
    end

    // asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_mask", fill_mask, 8'h00);
    check("arst_pulses", {6'd0, frame_valid, timeout_err}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    send_byte(8'hC6);
    check("arst_next_fv", {7'd0, frame_valid}, 8'h01);
    check("arst_next_dout", dout, 8'hC6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
